// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter merging MPN TCB manager ports onto one subordinate port.
// The grant is combinational when idle and held while the subordinate stalls; responses are routed back through a delay line.
module tcb_lib_arbiter #(
  parameter  int unsigned MPN = 2,
  parameter  int unsigned ADR = 32,
  parameter  int unsigned DAT = 32,
  parameter  int unsigned DLY = 1,
  localparam int unsigned BEN = DAT/8,
  localparam int unsigned IW  = $clog2(MPN)
)(
  input  logic               clk,
  input  logic               rst,
  // manager ports
  input  logic [MPN-1:0]     man_vld,
  output logic [MPN-1:0]     man_rdy,
  input  logic [MPN-1:0]     man_wen,
  input  logic [MPN*ADR-1:0] man_adr,
  input  logic [MPN*BEN-1:0] man_ben,
  input  logic [MPN*DAT-1:0] man_wdt,
  output logic [MPN*DAT-1:0] man_rdt,
  output logic [MPN-1:0]     man_sts,
  // subordinate port
  output logic               sub_vld,
  input  logic               sub_rdy,
  output logic               sub_wen,
  output logic [ADR-1:0]     sub_adr,
  output logic [BEN-1:0]     sub_ben,
  output logic [DAT-1:0]     sub_wdt,
  input  logic [DAT-1:0]     sub_rdt,
  input  logic               sub_sts,
  // response routing
  output logic [IW-1:0]      rsp_idx,
  output logic               rsp_vld
);

  typedef enum logic {ST_OPEN, ST_LOCK} lck_st_t;

  lck_st_t          st_q, st_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    gnt_q;
  logic [IW-1:0]    gnt_rr;
  logic [IW-1:0]    gnt;
  logic             lck;
  logic             trn;
  logic             found;
  int unsigned      scan;

  logic [ADR-1:0]   adr_a [MPN];
  logic [BEN-1:0]   ben_a [MPN];
  logic [DAT-1:0]   wdt_a [MPN];

  // Round-robin scan starting just after the last granted port
  always_comb begin
    gnt_rr = ptr_q;
    found  = 1'b0;
    scan   = 0;
    for (int unsigned k = 1; k <= MPN; k++) begin
      scan = (32'(ptr_q) + k) % MPN;
      if (!found && man_vld[IW'(scan)]) begin
        gnt_rr = IW'(scan);
        found  = 1'b1;
      end
    end
  end

  // Reset overrides a held lock so the unlocked grant is visible during reset
  assign lck     = (st_q == ST_LOCK) && !rst;
  assign gnt     = lck ? gnt_q : gnt_rr;
  assign sub_vld = (|man_vld) | lck;
  assign trn     = sub_vld & sub_rdy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_OPEN;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_OPEN: if (sub_vld && !sub_rdy) st_d = ST_LOCK;
      ST_LOCK: if (sub_rdy)             st_d = ST_OPEN;
      default:                          st_d = ST_OPEN;
    endcase
  end

  // Grant is captured every open cycle; it becomes the held grant on lock entry
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= IW'(MPN-1);
    end else begin
      if (st_q == ST_OPEN) gnt_q <= gnt_rr;
      if (trn)             ptr_q <= gnt;
    end
  end

  for (genvar i = 0; i < MPN; i++) begin : g_port
    assign adr_a[i]   = man_adr[i*ADR +: ADR];
    assign ben_a[i]   = man_ben[i*BEN +: BEN];
    assign wdt_a[i]   = man_wdt[i*DAT +: DAT];
    assign man_rdy[i] = sub_rdy & ~rst & (gnt == IW'(i));
    assign man_sts[i] = sub_sts & rsp_vld & (rsp_idx == IW'(i));
  end

  assign sub_wen = man_wen[gnt];
  assign sub_adr = adr_a[gnt];
  assign sub_ben = ben_a[gnt];
  assign sub_wdt = wdt_a[gnt];
  assign man_rdt = {MPN{sub_rdt}};

  // Response delay line of {valid, index}
  if (DLY == 0) begin : g_rsp_comb
    assign rsp_vld = trn;
    assign rsp_idx = gnt;
  end else begin : g_rsp_pipe
    logic [DLY-1:0]    pv_q;
    logic [DLY*IW-1:0] pi_q;

    always_ff @(posedge clk) begin
      if (rst) pv_q <= '0;
      else     pv_q <= DLY'({pv_q, trn});
    end

    always_ff @(posedge clk) begin
      pi_q <= (DLY*IW)'({pi_q, gnt});
    end

    assign rsp_vld = pv_q[DLY-1] & ~rst;
    assign rsp_idx = pi_q[DLY*IW-1 -: IW];
  end

  // A locked manager must keep its request up until the transfer completes
  always @(posedge clk) begin
    if (lck) begin
      assert (man_vld[gnt_q])
        else $error("tcb_lib_arbiter: locked manager %0d dropped man_vld", gnt_q);
    end
  end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Directed bench for tcb_lib_arbiter (MPN=3, DLY=1) with a small memory subordinate,
// a round-robin/lock/response-queue reference model and hand-pinned expectations.
module tb_tcb_lib_arbiter;

  localparam int unsigned MPN = 3;
  localparam int unsigned ADR = 32;
  localparam int unsigned DAT = 32;
  localparam int unsigned DLY = 1;
  localparam int unsigned BEN = DAT/8;
  localparam int unsigned IW  = $clog2(MPN);

  logic               clk;
  logic               rst;
  logic [MPN-1:0]     man_vld;
  logic [MPN-1:0]     man_rdy;
  logic [MPN-1:0]     man_wen;
  logic [MPN*ADR-1:0] man_adr;
  logic [MPN*BEN-1:0] man_ben;
  logic [MPN*DAT-1:0] man_wdt;
  logic [MPN*DAT-1:0] man_rdt;
  logic [MPN-1:0]     man_sts;
  logic               sub_vld;
  logic               sub_rdy;
  logic               sub_wen;
  logic [ADR-1:0]     sub_adr;
  logic [BEN-1:0]     sub_ben;
  logic [DAT-1:0]     sub_wdt;
  logic [DAT-1:0]     sub_rdt;
  logic               sub_sts;
  logic [IW-1:0]      rsp_idx;
  logic               rsp_vld;

  tcb_lib_arbiter #(.MPN(MPN), .ADR(ADR), .DAT(DAT), .DLY(DLY)) dut (
    .clk     (clk),
    .rst     (rst),
    .man_vld (man_vld),
    .man_rdy (man_rdy),
    .man_wen (man_wen),
    .man_adr (man_adr),
    .man_ben (man_ben),
    .man_wdt (man_wdt),
    .man_rdt (man_rdt),
    .man_sts (man_sts),
    .sub_vld (sub_vld),
    .sub_rdy (sub_rdy),
    .sub_wen (sub_wen),
    .sub_adr (sub_adr),
    .sub_ben (sub_ben),
    .sub_wdt (sub_wdt),
    .sub_rdt (sub_rdt),
    .sub_sts (sub_sts),
    .rsp_idx (rsp_idx),
    .rsp_vld (rsp_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory subordinate: writes land on the transfer edge, read data appears one cycle later
  logic [DAT-1:0] mem [16];
  logic [DAT-1:0] rdt_q;
  assign sub_rdt = rdt_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      rdt_q <= '0;
    end else if (sub_vld && sub_rdy) begin
      if (sub_wen) begin
        for (int b = 0; b < 4; b++)
          if (sub_ben[b]) mem[sub_adr[5:2]][b*8 +: 8] <= sub_wdt[b*8 +: 8];
      end else begin
        rdt_q <= mem[sub_adr[5:2]];
      end
    end
  end

  // One directed vector per cycle; p* fields are hand-computed pins (-1 = not pinned)
  typedef struct {
    logic           rst;
    logic [MPN-1:0] vld;
    logic [MPN-1:0] wen;
    logic           rdy;
    logic           sts;
    logic [ADR-1:0] adr;
    logic [DAT-1:0] wdt;
    int             pg;
    int             prv;
    int             pri;
    int             psts;
    int             prdt;
  } vec_t;

  typedef struct {
    int due;
    int idx;
  } rsp_t;

  vec_t vq[$];
  rsp_t rq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [MPN-1:0] vld, input logic [MPN-1:0] wen,
                     input logic rdy, input logic sts, input logic [ADR-1:0] adr,
                     input logic [DAT-1:0] wdt, input int pg, input int prv, input int pri,
                     input int psts, input int prdt);
    vec_t v;
    v.rst = r; v.vld = vld; v.wen = wen; v.rdy = rdy; v.sts = sts; v.adr = adr; v.wdt = wdt;
    v.pg = pg; v.prv = prv; v.pri = pri; v.psts = psts; v.prdt = prdt;
    vq.push_back(v);
  endtask

  task automatic chk(input int n, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h expected %0h", n, nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [MPN-1:0] vv);
    int j;
    for (int k = 1; k <= int'(MPN); k++) begin
      j = (p + k) % int'(MPN);
      if (((vv >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  localparam logic [DAT-1:0] WD = 32'h00C0_FFEE;

  initial begin
    vec_t v;
    int   ptr_m;
    bit   lck_m;
    int   held_m;
    bit   lk, e_svld, e_rv, trn;
    int   g, e_ri;

    rst = 1'b1; man_vld = '0; man_wen = '0; man_adr = '0; man_ben = '0; man_wdt = '0;
    sub_rdy = 1'b0; sub_sts = 1'b0;

    //   rst vld     wen     rdy sts adr    wdt           pg  prv pri psts prdt
    add(1, 3'b000, 3'b000, 1, 0, 32'h0, WD,           -1, 0, -1, 0, -1);
    add(1, 3'b011, 3'b000, 1, 0, 32'h0, WD,            0, 0, -1, 0, -1);
    add(0, 3'b011, 3'b000, 1, 0, 32'h0, WD,            0, 0, -1, -1, -1);
    add(0, 3'b011, 3'b000, 1, 0, 32'h0, WD,            1, 1,  0, -1, -1);
    add(0, 3'b011, 3'b000, 1, 0, 32'h0, WD,            0, 1,  1, -1, -1);
    add(0, 3'b011, 3'b000, 1, 0, 32'h0, WD,            1, 1,  0, -1, -1);
    add(0, 3'b001, 3'b000, 1, 0, 32'h0, WD,            0, 1,  1, -1, -1);
    add(0, 3'b001, 3'b000, 1, 0, 32'h0, WD,            0, 1,  0, -1, -1);
    add(0, 3'b001, 3'b000, 1, 0, 32'h0, WD,            0, 1,  0, -1, -1);
    add(0, 3'b001, 3'b000, 1, 0, 32'h0, WD,            0, 1,  0, -1, -1);
    add(0, 3'b010, 3'b000, 1, 0, 32'h0, WD,            1, 1,  0, -1, -1);
    add(0, 3'b010, 3'b000, 0, 0, 32'h0, WD,            1, 1,  1, -1, -1);
    add(0, 3'b011, 3'b000, 0, 0, 32'h0, WD,            1, 0, -1, -1, -1);
    add(0, 3'b011, 3'b000, 0, 0, 32'h0, WD,            1, 0, -1, -1, -1);
    add(0, 3'b011, 3'b000, 1, 0, 32'h0, WD,            1, 0, -1, -1, -1);
    add(0, 3'b001, 3'b000, 1, 0, 32'h0, WD,            0, 1,  1, -1, -1);
    add(0, 3'b001, 3'b001, 1, 0, 32'h0, 32'h01234567,  0, 1,  0, -1, -1);
    add(0, 3'b010, 3'b000, 1, 0, 32'h0, WD,            1, 1,  0, -1, -1);
    add(0, 3'b000, 3'b000, 1, 1, 32'h0, WD,           -1, 1,  1, 2, 32'h01234567);
    add(0, 3'b010, 3'b000, 1, 0, 32'h0, WD,            1, 0, -1, 0, -1);
    add(0, 3'b110, 3'b000, 0, 0, 32'h0, WD,            2, 1,  1, -1, -1);
    add(1, 3'b111, 3'b000, 0, 1, 32'h0, WD,           -1, 0, -1, 0, -1);
    add(0, 3'b111, 3'b000, 1, 0, 32'h0, WD,            0, 0, -1, -1, -1);
    add(1, 3'b111, 3'b000, 1, 1, 32'h0, WD,           -1, 0, -1, 0, -1);
    add(0, 3'b111, 3'b000, 1, 0, 32'h0, WD,            0, 0, -1, 0, -1);
    add(0, 3'b000, 3'b000, 1, 0, 32'h0, WD,           -1, 1,  0, -1, -1);
    add(0, 3'b000, 3'b000, 1, 0, 32'h0, WD,           -1, 0, -1, 0, -1);

    ptr_m = int'(MPN) - 1; lck_m = 1'b0; held_m = 0;

    foreach (vq[n]) begin
      @(negedge clk);
      v       = vq[n];
      rst     = v.rst;
      man_vld = v.vld;
      man_wen = v.wen;
      man_adr = {MPN{v.adr}};
      man_ben = '1;
      man_wdt = {v.wdt | 32'h2000_0000, v.wdt | 32'h1000_0000, v.wdt};
      sub_rdy = v.rdy;
      sub_sts = v.sts;
      #2;

      // expected outputs from the arbitration rules
      lk     = lck_m && !v.rst;
      g      = lk ? held_m : rr_pick(ptr_m, v.vld);
      e_svld = (v.vld != '0) || lk;
      chk(n, "sub_vld", 128'(sub_vld), 128'(e_svld));
      if (v.rst)
        chk(n, "man_rdy", 128'(man_rdy), 128'(0));
      else if (e_svld)
        chk(n, "man_rdy", 128'(man_rdy), v.rdy ? 128'(1 << g) : 128'(0));
      if (e_svld) begin
        chk(n, "sub_wen", 128'(sub_wen), 128'((v.wen >> g) & 3'b001));
        chk(n, "sub_adr", 128'(sub_adr), 128'(v.adr));
        chk(n, "sub_ben", 128'(sub_ben), 128'(4'hF));
        chk(n, "sub_wdt", 128'(sub_wdt), 128'(v.wdt | (32'(g) << 28)));
      end
      e_rv = !v.rst && rq.size() > 0 && rq[0].due == n;
      e_ri = e_rv ? rq[0].idx : 0;
      chk(n, "rsp_vld", 128'(rsp_vld), 128'(e_rv));
      if (e_rv) chk(n, "rsp_idx", 128'(rsp_idx), 128'(e_ri));
      chk(n, "man_sts", 128'(man_sts), (e_rv && v.sts) ? 128'(1 << e_ri) : 128'(0));
      chk(n, "man_rdt", 128'(man_rdt), 128'({MPN{sub_rdt}}));

      // hand-computed pins
      if (v.pg   >= 0) chk(n, "pin_gnt",     128'(sub_wdt[31:28]),  128'(v.pg));
      if (v.prv  >= 0) chk(n, "pin_rsp_vld", 128'(rsp_vld),         128'(v.prv));
      if (v.pri  >= 0) chk(n, "pin_rsp_idx", 128'(rsp_idx),         128'(v.pri));
      if (v.psts >= 0) chk(n, "pin_man_sts", 128'(man_sts),         128'(v.psts));
      if (v.prdt >= 0) chk(n, "pin_man_rdt", 128'(man_rdt[63:32]),  128'(v.prdt));

      // advance the model to the state after the coming rising edge
      trn = !v.rst && e_svld && v.rdy;
      if (v.rst) begin
        ptr_m = int'(MPN) - 1;
        lck_m = 1'b0;
        rq.delete();
      end else begin
        while (rq.size() > 0 && rq[0].due <= n) void'(rq.pop_front());
        if (trn) begin
          rsp_t r;
          r.due = n + int'(DLY);
          r.idx = g;
          ptr_m = g;
          rq.push_back(r);
        end
        if (!lck_m && e_svld && !v.rdy) begin
          lck_m  = 1'b1;
          held_m = g;
        end else if (lck_m && v.rdy) begin
          lck_m = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
